rotating_banner_mux: RTL and testbench

Parametrised rotating seven-segment banner: holds a writable message of MSG_LEN hex digits and shows a NUM_DIG-wide window of it on a time-multiplexed common-anode display. The window shifts left or right at a programmable rate. It is the general successor of the fixed 10-digit/4-display banner, adding runtime message writes, a step indicator and parametrised scan/rotate rates. It sits between board controls and the display pins, the same position the banner exercise occupies.

---
 rtl/banner_pkg.sv | 59 +++++
 rtl/seg7_hex_decoder.sv | 13 +
 rtl/rotating_banner_mux.sv | 123 ++++++++++++
 tb/tb_rotating_banner_mux.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/banner_pkg.sv
// Shared definitions for the rotating seven-segment banner.
// Glyphs are {g,f,e,d,c,b,a} and active-low, so a 0 bit lights a segment.
//   hex_to_seg : 4-bit hex digit -> 7-bit active-low glyph
//   wrap_add   : (ptr + off) mod len, valid for ptr < len and off <= len
package banner_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b0000011;
  localparam logic [6:0] SEG_C = 7'b1000110;
  localparam logic [6:0] SEG_D = 7'b0100001;
  localparam logic [6:0] SEG_E = 7'b0000110;
  localparam logic [6:0] SEG_F = 7'b0001110;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
    logic [6:0] seg;
    case (hex)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      default: seg = SEG_F;
    endcase
    return seg;
  endfunction

  // A single conditional subtract is enough because both operands stay
  // below len, so no divider is needed.
  function automatic logic [31:0] wrap_add(input logic [31:0] ptr,
                                           input logic [31:0] off,
                                           input logic [31:0] len);
    logic [31:0] s;
    s = ptr + off;
    if (s >= len) s = s - len;
    return s;
  endfunction

endpackage

// File: rtl/seg7_hex_decoder.sv
// Combinational hex-to-seven-segment decoder.
//   i_hex : hex digit to show
//   o_seg : {g,f,e,d,c,b,a}, active-low
module seg7_hex_decoder
  import banner_pkg::*;
(
  input  logic [3:0] i_hex,
  output logic [6:0] o_seg
);

  assign o_seg = hex_to_seg(i_hex);

endmodule

// File: rtl/rotating_banner_mux.sv
// Rotating seven-segment banner. Holds a writable MSG_LEN-digit hex message
// and scans an NUM_DIG-wide window of it onto a common-anode display; the
// window start (ptr) moves one digit every ROT_DIV enabled cycles.
//   clock, reset      : system clock, asynchronous active-high reset
//   en, dir           : rotation enable, direction (0 = ptr+1, 1 = ptr-1)
//   wr_en/addr/data   : message write port, out-of-range addresses ignored
//   segment, anode    : registered active-low display drive
//   step              : one-cycle pulse after every ptr update
module rotating_banner_mux
  import banner_pkg::*;
#(
  parameter int MSG_LEN = 10,
  parameter int NUM_DIG = 4,
  parameter int ROT_DIV = 50_000_000,
  parameter int REF_DIV = 50_000
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       en,
  input  logic                       dir,
  input  logic                       wr_en,
  input  logic [$clog2(MSG_LEN)-1:0] wr_addr,
  input  logic [3:0]                 wr_data,
  output logic [6:0]                 segment,
  output logic [NUM_DIG-1:0]         anode,
  output logic                       step
);

  localparam int AW = $clog2(MSG_LEN);
  localparam int SW = (NUM_DIG > 1) ? $clog2(NUM_DIG) : 1;
  localparam int RW = (ROT_DIV > 1) ? $clog2(ROT_DIV) : 1;
  localparam int FW = (REF_DIV > 1) ? $clog2(REF_DIV) : 1;

  logic [3:0]         r_msg [MSG_LEN];
  logic [AW-1:0]      r_ptr;
  logic [SW-1:0]      r_sel;
  logic [RW-1:0]      r_rot_cnt;
  logic [FW-1:0]      r_ref_cnt;
  logic               r_step;
  logic [6:0]         r_segment;
  logic [NUM_DIG-1:0] r_anode;

  logic               w_rot_wrap;
  logic               w_ref_wrap;
  logic               w_wr_ok;
  logic [AW-1:0]      w_ptr_next;
  logic [AW-1:0]      w_idx;
  logic [3:0]         w_digit;
  logic [6:0]         w_seg;
  logic [NUM_DIG-1:0] w_anode;

  assign w_rot_wrap = (r_rot_cnt == RW'(ROT_DIV - 1));
  assign w_ref_wrap = (r_ref_cnt == FW'(REF_DIV - 1));
  assign w_wr_ok    = wr_en && (int'(wr_addr) < MSG_LEN);

  always_comb begin
    w_ptr_next = r_ptr;
    if (dir) begin
      w_ptr_next = (r_ptr == '0) ? AW'(MSG_LEN - 1) : r_ptr - AW'(1);
    end else begin
      w_ptr_next = (r_ptr == AW'(MSG_LEN - 1)) ? '0 : r_ptr + AW'(1);
    end
  end

  // Digit sel shows msg[ptr+sel] on anode bit NUM_DIG-1-sel (leftmost first).
  assign w_idx   = AW'(wrap_add(32'(r_ptr), 32'(r_sel), 32'(MSG_LEN)));
  assign w_digit = r_msg[w_idx];

  always_comb begin
    w_anode = '1;
    for (int i = 0; i < NUM_DIG; i++) begin
      w_anode[i] = (i != (NUM_DIG - 1 - int'(r_sel)));
    end
  end

  seg7_hex_decoder u_dec (
    .i_hex (w_digit),
    .o_seg (w_seg)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < MSG_LEN; i++) r_msg[i] <= 4'(i % 10);
      r_ptr     <= '0;
      r_sel     <= '0;
      r_rot_cnt <= '0;
      r_ref_cnt <= '0;
      r_step    <= 1'b0;
      r_segment <= SEG_BLANK;
      r_anode   <= '1;
    end else begin
      if (w_wr_ok) r_msg[wr_addr] <= wr_data;

      // Rotation: counter and pointer freeze while en is low.
      r_step <= 1'b0;
      if (en) begin
        if (w_rot_wrap) begin
          r_rot_cnt <= '0;
          r_ptr     <= w_ptr_next;
          r_step    <= 1'b1;
        end else begin
          r_rot_cnt <= r_rot_cnt + RW'(1);
        end
      end

      // Scanning runs regardless of en.
      if (w_ref_wrap) begin
        r_ref_cnt <= '0;
        r_sel     <= (r_sel == SW'(NUM_DIG - 1)) ? '0 : r_sel + SW'(1);
      end else begin
        r_ref_cnt <= r_ref_cnt + FW'(1);
      end

      r_segment <= w_seg;
      r_anode   <= w_anode;
    end
  end

  assign segment = r_segment;
  assign anode   = r_anode;
  assign step    = r_step;

endmodule

// File: tb/tb_rotating_banner_mux.sv
// Directed bench for rotating_banner_mux with MSG_LEN=10, NUM_DIG=4,
// ROT_DIV=4, REF_DIV=2.
module tb_rotating_banner_mux;

  logic       clock;
  logic       reset;
  logic       en;
  logic       dir;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [3:0] wr_data;
  logic [6:0] segment;
  logic [3:0] anode;
  logic       step;

  int n_cmp  = 0;
  int n_fail = 0;

  rotating_banner_mux #(
    .MSG_LEN (10),
    .NUM_DIG (4),
    .ROT_DIV (4),
    .REF_DIV (2)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .en      (en),
    .dir     (dir),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .segment (segment),
    .anode   (anode),
    .step    (step)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [6:0] glyph(input logic [3:0] h);
    logic [6:0] g;
    case (h)
      4'h0: g = 7'b1000000;  4'h1: g = 7'b1111001;
      4'h2: g = 7'b0100100;  4'h3: g = 7'b0110000;
      4'h4: g = 7'b0011001;  4'h5: g = 7'b0010010;
      4'h6: g = 7'b0000010;  4'h7: g = 7'b1111000;
      4'h8: g = 7'b0000000;  4'h9: g = 7'b0010000;
      4'hA: g = 7'b0001000;  4'hB: g = 7'b0000011;
      4'hC: g = 7'b1000110;  4'hD: g = 7'b0100001;
      4'hE: g = 7'b0000110;  default: g = 7'b0001110;
    endcase
    return g;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Runs n enabled cycles and checks that step fires on every 4th one,
  // starting from rot_cnt = 0.
  task automatic run_steps(input string name, input int n);
    logic exp;
    en = 1'b1;
    for (int k = 1; k <= n; k++) begin
      tick();
      exp = (k % 4 == 0);
      n_cmp++;
      if (step !== exp) begin
        n_fail++;
        $display("FAIL %s cycle %0d: step=%b expected %b", name, k, step, exp);
      end
    end
    en = 1'b0;
  endtask

  // Watches 8 cycles with en=0 and checks the glyph shown at every position.
  task automatic check_window(input string name, input logic [3:0] d0,
                              input logic [3:0] d1, input logic [3:0] d2,
                              input logic [3:0] d3);
    logic [3:0] exp_d [4];
    logic [6:0] seen  [4];
    bit         got   [4];
    int         pos;
    exp_d[0] = d0; exp_d[1] = d1; exp_d[2] = d2; exp_d[3] = d3;
    for (int p = 0; p < 4; p++) begin
      got[p] = 1'b0;
      seen[p] = 7'h7F;
    end
    for (int c = 0; c < 8; c++) begin
      tick();
      case (anode)
        4'b0111: pos = 0;
        4'b1011: pos = 1;
        4'b1101: pos = 2;
        4'b1110: pos = 3;
        default: pos = -1;
      endcase
      if (pos < 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL %s onehot: anode=%b expected exactly one bit low", name, anode);
      end else begin
        got[pos]  = 1'b1;
        seen[pos] = segment;
      end
    end
    for (int p = 0; p < 4; p++) begin
      n_cmp++;
      if (!got[p] || seen[p] !== glyph(exp_d[p])) begin
        n_fail++;
        $display("FAIL %s digit%0d: segment=%b (seen=%0d) expected %b (hex %h)",
                 name, p, seen[p], got[p], glyph(exp_d[p]), exp_d[p]);
      end
    end
  endtask

  task automatic test_reset();
    logic [3:0] exp_an [8];
    logic [3:0] exp_dg [8];
    exp_an = '{4'b0111, 4'b0111, 4'b1011, 4'b1011,
               4'b1101, 4'b1101, 4'b1110, 4'b1110};
    exp_dg = '{4'h0, 4'h0, 4'h1, 4'h1, 4'h2, 4'h2, 4'h3, 4'h3};
    reset = 1'b1; en = 1'b0; dir = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    #2;
    tick();
    tick();
    n_cmp++;
    if (anode !== 4'b1111) begin
      n_fail++; $display("FAIL reset_anode: %b expected 1111", anode);
    end
    n_cmp++;
    if (segment !== 7'h7F) begin
      n_fail++; $display("FAIL reset_segment: %h expected 7f", segment);
    end
    n_cmp++;
    if (step !== 1'b0) begin
      n_fail++; $display("FAIL reset_step: %b expected 0", step);
    end
    reset = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick();
      n_cmp++;
      if (anode !== exp_an[c]) begin
        n_fail++; $display("FAIL scan_anode cycle %0d: %b expected %b", c, anode, exp_an[c]);
      end
      n_cmp++;
      if (segment !== glyph(exp_dg[c])) begin
        n_fail++;
        $display("FAIL scan_segment cycle %0d: %b expected %b", c, segment, glyph(exp_dg[c]));
      end
    end
  endtask

  task automatic test_forward();
    dir = 1'b0;
    run_steps("fwd7", 28);
    check_window("fwd7_window", 4'h7, 4'h8, 4'h9, 4'h0);
    run_steps("fwd10", 12);
    check_window("fwd10_window", 4'h0, 4'h1, 4'h2, 4'h3);
  endtask

  task automatic test_backward();
    dir = 1'b1;
    run_steps("back1", 4);
    check_window("back1_window", 4'h9, 4'h0, 4'h1, 4'h2);
    dir = 1'b0;
    run_steps("back_restore", 4);
    check_window("back_restore_window", 4'h0, 4'h1, 4'h2, 4'h3);
  endtask

  task automatic test_pause();
    logic [3:0] mask;
    en = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      n_cmp++;
      if (step !== 1'b0) begin
        n_fail++; $display("FAIL pause_pre cycle %0d: step=%b expected 0", k, step);
      end
    end
    en = 1'b0;
    mask = 4'b0000;
    for (int k = 0; k < 20; k++) begin
      tick();
      mask = mask | ~anode;
      n_cmp++;
      if (step !== 1'b0) begin
        n_fail++; $display("FAIL pause_hold cycle %0d: step=%b expected 0", k, step);
      end
    end
    n_cmp++;
    if (mask !== 4'b1111) begin
      n_fail++; $display("FAIL pause_scan: anodes lit %b expected 1111", mask);
    end
    en = 1'b1;
    tick();
    n_cmp++;
    if (step !== 1'b0) begin
      n_fail++; $display("FAIL pause_resume1: step=%b expected 0", step);
    end
    tick();
    n_cmp++;
    if (step !== 1'b1) begin
      n_fail++; $display("FAIL pause_resume2: step=%b expected 1", step);
    end
    en = 1'b0;
    check_window("pause_window", 4'h1, 4'h2, 4'h3, 4'h4);
    dir = 1'b1;
    run_steps("pause_restore", 4);
    dir = 1'b0;
  endtask

  task automatic test_write();
    wr_en = 1'b1; wr_addr = 4'd1; wr_data = 4'hE;
    tick();
    wr_en = 1'b0;
    check_window("write_addr1", 4'h0, 4'hE, 4'h2, 4'h3);
    wr_en = 1'b1; wr_addr = 4'd12; wr_data = 4'h5;
    tick();
    wr_en = 1'b0;
    check_window("write_addr12", 4'h0, 4'hE, 4'h2, 4'h3);
  endtask

  task automatic test_write_with_step();
    en = 1'b1;
    tick(); tick(); tick();
    wr_en = 1'b1; wr_addr = 4'd4; wr_data = 4'hA;
    tick();
    wr_en = 1'b0; en = 1'b0;
    n_cmp++;
    if (step !== 1'b1) begin
      n_fail++; $display("FAIL wr_step_pulse: step=%b expected 1", step);
    end
    check_window("wr_step_window", 4'hE, 4'h2, 4'h3, 4'hA);
  endtask

  task automatic test_reset_midrun();
    run_steps("pre_reset", 8);
    check_window("pre_reset_window", 4'h3, 4'hA, 4'h5, 4'h6);
    en = 1'b1;
    tick();
    #3;
    reset = 1'b1;
    wr_en = 1'b1; wr_addr = 4'd0; wr_data = 4'hF;
    #1;
    n_cmp++;
    if (anode !== 4'b1111) begin
      n_fail++; $display("FAIL async_reset_anode: %b expected 1111", anode);
    end
    n_cmp++;
    if (segment !== 7'h7F) begin
      n_fail++; $display("FAIL async_reset_segment: %h expected 7f", segment);
    end
    tick();
    reset = 1'b0; wr_en = 1'b0; en = 1'b0;
    check_window("post_reset_window", 4'h0, 4'h1, 4'h2, 4'h3);
  endtask

  initial begin
    test_reset();
    test_forward();
    test_backward();
    test_pause();
    test_write();
    test_write_with_step();
    test_reset_midrun();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
